parallel_serial_param: RTL and testbench
========================================

# parallel_serial_param

- Parametrised parallel-to-serial converter for the serial link transmit path.
- Accepts DATA_WIDTH-bit words through a valid/ready handshake into a one-word holding buffer and shifts them out one bit per clk_32f.
- Inserts IDLE_WORD whenever no data is ready at a word boundary.
- Supersedes the fixed 8-bit converter: adds configurable width, bit order, back-pressure, frame and data markers, and underrun reporting.

## Interface
Parameters:
- DATA_WIDTH, 8: word width W; legal range 2..32.
- IDLE_WORD, 8'hBC: word transmitted when no data is available; W bits wide.
- LSB_FIRST, 0: 0 sends bit W-1 first, 1 sends bit 0 first.

Ports:
- clk_32f  in  1  bit clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- valid_in  in  1  data_in valid.
- data_in  in  W  parallel word.
- ready_out  out  1  buffer can accept; equals !hold_v (combinational from state only).
- data_out  out  1  serial bit.
- frame_out  out  1  high during the first bit of every word, data or idle.
- data_flag  out  1  high during every bit of a data word; low during idle words.
- underrun  out  1  one-cycle pulse; see Operation.

## Operation
Registers:
- sh[W-1:0]: shift register.
- cnt[CW-1:0]: bit counter, CW = $clog2(W).
- hold[W-1:0], hold_v: holding buffer and its valid flag.
- cur_data: current word is data.
- prev_data: previous word was data.

Reset values (on assertion, immediately):
- sh=0, cnt=W-1, hold_v=0, cur_data=0, prev_data=0, underrun=0.
- Resulting outputs: data_out=0, frame_out=0, data_flag=0, ready_out=1.
- Reset mid-word discards the partial word and any held word.

Signals:
- accept = valid_in & ready_out.
- boundary = (cnt == W-1).

Non-boundary edge:
- sh shifts by one toward the output end: left for MSB-first, right for LSB-first; vacated bit fills with 0.
- cnt increments.

Boundary edge:
- cnt wraps to 0; prev_data <= cur_data.
- sh is loaded by priority:
  - hold_v=1: load hold; hold_v<=0; cur_data<=1.
  - else if accept: load data_in directly (bypass; hold stays empty); cur_data<=1.
  - else: load IDLE_WORD; cur_data<=0.

Buffering:
- accept on a non-boundary edge writes hold and sets hold_v.
- While hold_v=1, ready_out=0; valid_in and data_in are ignored.

Outputs:
- data_out = LSB_FIRST ? sh[0] : sh[W-1].
- frame_out = (cnt==0) after the first boundary since reset.
- data_flag = cur_data.

Underrun:
- Registered pulse, high for the W=0 cycle (cnt==0) of an idle word whose predecessor was data (prev_data & !cur_data).

## Timing
- First boundary is the first rising edge after reset deasserts. With no data pending it loads IDLE_WORD, and frame_out rises.
- Latency, accept on a boundary edge: first bit of the word appears on data_out in the following cycle, i.e. straight after that edge.
- Latency, accept on a non-boundary edge: word waits in hold until the next boundary; worst case W-1 cycles.
- Sustained throughput: one word per W cycles. A producer keeping valid_in high sees ready_out drop for 1..W-1 cycles per word.
- A word is transmitted exactly once. No word is lost or duplicated under any valid_in pattern.
- Simultaneous boundary and hold_v=1: hold is consumed; ready_out is 0 that cycle, so no new accept.

## Structure
- Shared package parallel_serial_pkg holds:
  - localparam defaults: PS_WIDTH=8, PS_IDLE=8'hBC.
  - function ps_cnt_width(W) returning $clog2(W).
- One sub-module is natural: ps_hold_buf, the one-word holding register with the valid/ready logic and the boundary consume input.
- Counter, shift register and flags stay in parallel_serial_param.

## Test plan
- Reset then idle, W=8, MSB-first, valid_in=0 for 32 cycles:
  - data_out repeats 1,0,1,1,1,1,0,0 (0xBC).
  - frame_out pulses every 8 cycles; data_flag=0; underrun=0.
- Back-to-back data 0xFF, 0xEE, 0xAA, valid_in held high:
  - serial stream FF EE AA, each word once, contiguous with no idle between.
  - data_flag high for 24 bits; ready_out low while hold is full.
  - then 0xBC follows, with underrun=1 on its first bit.
- Accept on the boundary edge with hold empty, 0xCC:
  - bits 1,1,0,0,1,1,0,0 start on the very next cycle (bypass path).
- LSB_FIRST=1, W=16, IDLE_WORD=16'hAAAA, send 16'h1234:
  - bit order 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0; frame_out period 16.
- Async reset asserted at bit 3 of 0xEE with a word pending in hold:
  - outputs go to reset values at once.
  - after release, IDLE_WORD is sent and neither 0xEE nor the held word is ever transmitted.

Source files
------------

// File: rtl/parallel_serial_pkg.sv
// Shared defaults and helpers for the serial-link parallel-to-serial converter.
package parallel_serial_pkg;
  localparam int         PS_WIDTH = 8;
  localparam logic [7:0] PS_IDLE  = 8'hBC;

  function automatic int ps_cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/ps_hold_buf.sv
// One-word holding buffer: captures a word accepted mid-word, releases it at the next boundary.
module ps_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk_32f,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  input  logic         boundary,
  output logic         ready_out,
  output logic [W-1:0] hold,
  output logic         hold_v
);
  logic accept;

  assign ready_out = !hold_v;
  assign accept    = valid_in & ready_out;

  // A boundary accept bypasses the buffer and goes straight into the shifter.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (boundary && hold_v) begin
      hold_v <= 1'b0;
    end else if (accept && !boundary) begin
      hold   <= data_in;
      hold_v <= 1'b1;
    end
  end
endmodule

// File: rtl/parallel_serial_param.sv
// Parallel-to-serial converter: W-bit words in via valid/ready, one bit per clk_32f out,
// IDLE_WORD filled in at word boundaries when nothing is pending.
module parallel_serial_param
  import parallel_serial_pkg::*;
#(
  parameter int                    DATA_WIDTH = PS_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = PS_IDLE,
  parameter bit                    LSB_FIRST  = 1'b0
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  frame_out,
  output logic                  data_flag,
  output logic                  underrun
);
  localparam int            W    = DATA_WIDTH;
  localparam int            CW   = ps_cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hold;
  logic          hold_v;
  logic          cur_data;
  logic          prev_data;
  logic          accept;
  logic          boundary;

  assign accept   = valid_in & ready_out;
  assign boundary = (cnt == LAST);

  ps_hold_buf #(.W(W)) u_hold (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in  (data_in),
    .boundary (boundary),
    .ready_out(ready_out),
    .hold     (hold),
    .hold_v   (hold_v)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sh        <= '0;
      cnt       <= LAST;
      cur_data  <= 1'b0;
      prev_data <= 1'b0;
      underrun  <= 1'b0;
    end else if (boundary) begin
      cnt       <= '0;
      prev_data <= cur_data;
      if (hold_v) begin
        sh       <= hold;
        cur_data <= 1'b1;
        underrun <= 1'b0;
      end else if (accept) begin
        sh       <= data_in;
        cur_data <= 1'b1;
        underrun <= 1'b0;
      end else begin
        sh       <= IDLE_WORD;
        cur_data <= 1'b0;
        underrun <= cur_data;
      end
    end else begin
      sh       <= LSB_FIRST ? (sh >> 1) : (sh << 1);
      cnt      <= cnt + 1'b1;
      underrun <= 1'b0;
    end
  end

  // cnt resets to W-1 (never 0 for W>=2), so frame_out stays low until the first boundary.
  assign data_out  = LSB_FIRST ? sh[0] : sh[W-1];
  assign frame_out = (cnt == '0);
  assign data_flag = cur_data;
endmodule

// File: tb/tb_parallel_serial_param.sv
// Randomized self-checking bench for parallel_serial_param against a word-queue reference model.
module tb_parallel_serial_param;
  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hBC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, ready, dout, frame, flag, und;
  logic [7:0]  din;
  logic        rst2_n, valid2, ready2, dout2, frame2, flag2, und2;
  logic [15:0] din2;

  int tests = 0;
  int fails = 0;

  parallel_serial_param #(.DATA_WIDTH(8), .IDLE_WORD(8'hBC), .LSB_FIRST(1'b0)) dut (
    .clk_32f(clk), .reset(rst_n), .valid_in(valid), .data_in(din), .ready_out(ready),
    .data_out(dout), .frame_out(frame), .data_flag(flag), .underrun(und)
  );

  parallel_serial_param #(.DATA_WIDTH(16), .IDLE_WORD(16'hAAAA), .LSB_FIRST(1'b1)) dut2 (
    .clk_32f(clk), .reset(rst2_n), .valid_in(valid2), .data_in(din2), .ready_out(ready2),
    .data_out(dout2), .frame_out(frame2), .data_flag(flag2), .underrun(und2)
  );

  // Reference model: current word + bit position, plus a queue of accepted-but-unsent words.
  int         m_pos;
  bit         m_started, m_data, m_und;
  logic [7:0] m_cur;
  logic [7:0] pend[$];

  task automatic m_reset();
    m_pos = W - 1; m_started = 0; m_data = 0; m_und = 0; m_cur = '0;
    pend.delete();
  endtask

  task automatic m_step(input bit v, input logic [7:0] d);
    bit acc, was;
    acc = v && (pend.size() == 0);
    if (m_pos == W - 1) begin
      was = m_data;
      if (pend.size() > 0) begin m_cur = pend.pop_front(); m_data = 1; end
      else if (acc)        begin m_cur = d; m_data = 1; end
      else                 begin m_cur = IDLE; m_data = 0; end
      m_und = was && !m_data;
      m_pos = 0;
      m_started = 1;
    end else begin
      if (acc) pend.push_back(d);
      m_pos++;
      m_und = 0;
    end
  endtask

  // {ready, data_out, frame_out, data_flag, underrun}
  function automatic logic [4:0] m_exp();
    logic b;
    b = m_started ? m_cur[W-1-m_pos] : 1'b0;
    return {(pend.size() == 0), b, (m_started && m_pos == 0), m_data, m_und};
  endfunction

  // Drive inputs for the next rising edge, advance the model, and land on the following negedge.
  task automatic drive(input bit v, input logic [7:0] d);
    valid = v; din = d;
    m_step(v, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; valid = 0; din = '0;
    rst2_n = 0; valid2 = 0; din2 = '0;
    m_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({ready, dout, frame, flag, und} !== 5'b10000) begin
      fails++; $display("FAIL reset_outputs: got %b want %b", {ready, dout, frame, flag, und}, 5'b10000);
    end
    tests++;
    if ({ready2, dout2, frame2, flag2, und2} !== 5'b10000) begin
      fails++; $display("FAIL reset_outputs_w16: got %b want %b", {ready2, dout2, frame2, flag2, und2}, 5'b10000);
    end
    rst_n = 1;
  endtask

  task automatic test_idle();
    logic [31:0] s;
    int fr;
    s = '0; fr = 0;
    for (int i = 0; i < 32; i++) begin
      drive(0, '0);
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp()) begin
        fails++; $display("FAIL idle_cycle %0d: got %b want %b", i, {ready, dout, frame, flag, und}, m_exp());
      end
      s = {s[30:0], dout};
      fr += int'(frame);
    end
    tests++;
    if (s !== 32'hBCBCBCBC) begin fails++; $display("FAIL idle_stream: got %h want %h", s, 32'hBCBCBCBC); end
    tests++;
    if (fr != 4) begin fails++; $display("FAIL idle_frames: got %0d want %0d", fr, 4); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w[3];
    logic [23:0] s;
    int k, nb, first, last, und_n;
    bit saw_low, v, acc;
    w[0] = 8'hFF; w[1] = 8'hEE; w[2] = 8'hAA;
    k = 0; nb = 0; first = -1; last = -1; und_n = 0; saw_low = 0; s = '0;
    for (int c = 0; c < 60; c++) begin
      v = (k < 3);
      acc = v && ready;
      drive(v, v ? w[k] : 8'h00);
      if (acc) k++;
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp()) begin
        fails++; $display("FAIL b2b_cycle %0d: got %b want %b", c, {ready, dout, frame, flag, und}, m_exp());
      end
      if (flag) begin
        if (nb < 24) s = {s[22:0], dout};
        nb++;
        if (first < 0) first = c;
        last = c;
      end
      if (!ready) saw_low = 1;
      und_n += int'(und);
    end
    tests++;
    if (s !== 24'hFFEEAA || nb != 24) begin
      fails++; $display("FAIL b2b_stream: got %h (%0d bits) want ffeeaa (24 bits)", s, nb);
    end
    tests++;
    if (last - first + 1 != 24) begin
      fails++; $display("FAIL b2b_contiguous: got span %0d want %0d", last - first + 1, 24);
    end
    tests++;
    if (!saw_low) begin fails++; $display("FAIL b2b_ready_low: got %0d want %0d", saw_low, 1); end
    tests++;
    if (und_n != 1) begin fails++; $display("FAIL b2b_underrun: got %0d pulses want %0d", und_n, 1); end
  endtask

  task automatic align_boundary(input string tag);
    int g;
    g = 0;
    while (!(m_pos == W - 1 && pend.size() == 0) && g < 40) begin
      drive(0, '0);
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp()) begin
        fails++; $display("FAIL %s_align: got %b want %b", tag, {ready, dout, frame, flag, und}, m_exp());
      end
      g++;
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e;
    e = 8'hCC;
    align_boundary("bypass");
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1, 8'hCC); else drive(0, '0);
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp() || dout !== e[7-i] || frame !== (i == 0) || flag !== 1'b1) begin
        fails++; $display("FAIL bypass_bit %0d: got %b want %b (bit %b)", i, {ready, dout, frame, flag, und}, m_exp(), e[7-i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] rx_w, d;
    int rx_cnt;
    bit rx_d, v;
    rx_cnt = -1; rx_w = '0; rx_d = 0;
    for (int c = 0; c < 640; c++) begin
      v = (c < 600) && ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      if (v && pend.size() == 0) txq.push_back(d);
      drive(v, d);
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp()) begin
        fails++; $display("FAIL random_cycle %0d: got %b want %b", c, {ready, dout, frame, flag, und}, m_exp());
      end
      if (frame) begin rx_cnt = 0; rx_w = '0; rx_d = flag; end
      if (rx_cnt >= 0 && rx_cnt < 8) begin
        rx_w = {rx_w[6:0], dout};
        rx_cnt++;
        if (rx_cnt == 8 && rx_d) rxq.push_back(rx_w);
      end
    end
    tests++;
    if (rxq.size() != txq.size()) begin
      fails++; $display("FAIL random_word_count: got %0d want %0d", rxq.size(), txq.size());
    end else begin
      for (int i = 0; i < txq.size(); i++) begin
        tests++;
        if (rxq[i] !== txq[i]) begin
          fails++; $display("FAIL random_word %0d: got %h want %h", i, rxq[i], txq[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int nflag;
    nflag = 0;
    align_boundary("areset");
    drive(1, 8'hEE);
    drive(1, 8'h55);
    drive(0, '0);
    drive(0, '0);
    tests++;
    if ({ready, dout, frame, flag, und} !== m_exp() || ready !== 1'b0) begin
      fails++; $display("FAIL areset_pre: got %b want %b", {ready, dout, frame, flag, und}, m_exp());
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({ready, dout, frame, flag, und} !== 5'b10000) begin
      fails++; $display("FAIL areset_immediate: got %b want %b", {ready, dout, frame, flag, und}, 5'b10000);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 40; c++) begin
      drive(0, '0);
      tests++;
      if ({ready, dout, frame, flag, und} !== m_exp()) begin
        fails++; $display("FAIL areset_after %0d: got %b want %b", c, {ready, dout, frame, flag, und}, m_exp());
      end
      nflag += int'(flag);
    end
    tests++;
    if (nflag != 0) begin fails++; $display("FAIL areset_no_data: got %0d data bits want %0d", nflag, 0); end
  endtask

  task automatic test_lsb_w16();
    logic [15:0] wd;
    logic [4:0]  e;
    valid2 = 1; din2 = 16'h1234; rst2_n = 1;
    @(negedge clk);
    valid2 = 0; din2 = '0;
    for (int k = 0; k < 48; k++) begin
      wd = (k < 16) ? 16'h1234 : 16'hAAAA;
      e  = {1'b1, wd[k % 16], (k % 16 == 0), (k < 16), (k == 16)};
      tests++;
      if ({ready2, dout2, frame2, flag2, und2} !== e) begin
        fails++; $display("FAIL lsb16_bit %0d: got %b want %b", k, {ready2, dout2, frame2, flag2, und2}, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle();
    test_back_to_back();
    test_bypass();
    test_random();
    test_async_reset();
    test_lsb_w16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
